// File: rtl/counter_pkg.sv
// Shared constants and elaboration helpers for the modulo counter and its prescaler.
package counter_pkg;

    localparam int unsigned WIDTH_MIN    = 1;
    localparam int unsigned WIDTH_MAX    = 32;
    localparam longint unsigned MODULO_MIN = 64'd2;
    localparam int unsigned PRESCALE_MIN = 1;
    localparam int unsigned PRESCALE_MAX = 65536;

    // Prescaler register width; never narrower than one bit.
    function automatic int unsigned psc_width(input int unsigned prescale);
        int unsigned w;
        w = $clog2(prescale);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic bit params_ok(input int unsigned width,
                                     input longint unsigned modulo,
                                     input int unsigned prescale);
        bit ok;
        ok = 1'b1;
        if (width < WIDTH_MIN || width > WIDTH_MAX) ok = 1'b0;
        if (modulo < MODULO_MIN) ok = 1'b0;
        if (width <= WIDTH_MAX && modulo > (64'd1 << width)) ok = 1'b0;
        if (prescale < PRESCALE_MIN || prescale > PRESCALE_MAX) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler: emits one tick every PRESCALE enabled cycles; restart discards partial counts.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    input  logic en_i,
    output logic tick_c_o
);

    localparam int unsigned PSC_W = psc_width(PRESCALE);
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

    logic [PSC_W-1:0] psc_q;
    logic [PSC_W-1:0] psc_d;

    always_comb begin
        psc_d = psc_q;
        if (restart_i) begin
            psc_d = '0;
        end else if (en_i) begin
            psc_d = (psc_q == PSC_LAST) ? '0 : psc_q + PSC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end

    assign tick_c_o = en_i && (psc_q == PSC_LAST);

endmodule

// File: rtl/counter_mod.sv
// Parametrised modulo up/down counter with clear, clamped load, prescaler, tc and wrap pulse.
// Define COUNTER_MOD_SATURATE_EN to saturate at the terminal value instead of wrapping.
module counter_mod
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MODULO   = 64'd1 << WIDTH,
    parameter int unsigned     PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_c_o,
    output logic             wrap_o
);

    // Computed in 64 bits so MODULO == 2**WIDTH gives an all-ones terminal value.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 64'd1);

    if (!params_ok(WIDTH, MODULO, PRESCALE)) begin : g_bad_params
        $error("counter_mod: illegal WIDTH/MODULO/PRESCALE combination");
    end

    logic             tick_c;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    logic [WIDTH-1:0] load_clamped_c;

    if (PRESCALE == 1) begin : g_no_psc
        assign tick_c = en_i;
    end else begin : g_psc
        counter_prescaler #(
            .PRESCALE (PRESCALE)
        ) u_psc (
            .clk       (clk),
            .rst       (rst),
            .restart_i (clr_i | load_i),
            .en_i      (en_i),
            .tick_c_o  (tick_c)
        );
    end

    assign load_clamped_c = (load_val_i > MAX_VAL) ? MAX_VAL : load_val_i;

    // Priority: clr > load > step; rst handled in the register.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_clamped_c;
        end else if (tick_c) begin
            if (up_i) begin
                if (count_q == MAX_VAL) begin
`ifdef COUNTER_MOD_SATURATE_EN
                    count_d = count_q;
`else
                    count_d = '0;
`endif
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
`ifdef COUNTER_MOD_SATURATE_EN
                    count_d = count_q;
`else
                    count_d = MAX_VAL;
`endif
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count_o = count_q;
    assign wrap_o  = wrap_q;
    assign tc_c_o  = up_i ? (count_q == MAX_VAL) : (count_q == '0);

endmodule

// File: tb/tb_counter_mod.sv
// Directed bench for counter_mod: vector table on a mod-10 counter plus prescaler and full-range sequences.
module tb_counter_mod;

`ifdef COUNTER_MOD_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic       clr;
        logic       en;
        logic       up;
        logic       load;
        logic [3:0] val;
        logic [3:0] exp_cnt;
        logic       exp_wrap;
        logic       exp_tc;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // DUT A: WIDTH=4, MODULO=10, PRESCALE=1
    logic       a_rst = 1'b1, a_clr = 1'b0, a_en = 1'b0, a_up = 1'b1, a_load = 1'b0;
    logic [3:0] a_val = 4'd0;
    logic [3:0] a_cnt;
    logic       a_tc, a_wrap;

    // DUT P: WIDTH=4, MODULO=10, PRESCALE=3
    logic       p_rst = 1'b1, p_clr = 1'b0, p_en = 1'b0, p_up = 1'b1, p_load = 1'b0;
    logic [3:0] p_val = 4'd0;
    logic [3:0] p_cnt;
    logic       p_tc, p_wrap;

    // DUT F: WIDTH=8, MODULO=256, PRESCALE=1
    logic       f_rst = 1'b1, f_clr = 1'b0, f_en = 1'b0, f_up = 1'b1, f_load = 1'b0;
    logic [7:0] f_val = 8'd0;
    logic [7:0] f_cnt;
    logic       f_tc, f_wrap;

    counter_mod #(.WIDTH(4), .MODULO(64'd10), .PRESCALE(1)) u_a (
        .clk(clk), .rst(a_rst), .clr_i(a_clr), .en_i(a_en), .up_i(a_up),
        .load_i(a_load), .load_val_i(a_val), .count_o(a_cnt), .tc_c_o(a_tc), .wrap_o(a_wrap)
    );

    counter_mod #(.WIDTH(4), .MODULO(64'd10), .PRESCALE(3)) u_p (
        .clk(clk), .rst(p_rst), .clr_i(p_clr), .en_i(p_en), .up_i(p_up),
        .load_i(p_load), .load_val_i(p_val), .count_o(p_cnt), .tc_c_o(p_tc), .wrap_o(p_wrap)
    );

    counter_mod #(.WIDTH(8), .MODULO(64'd256), .PRESCALE(1)) u_f (
        .clk(clk), .rst(f_rst), .clr_i(f_clr), .en_i(f_en), .up_i(f_up),
        .load_i(f_load), .load_val_i(f_val), .count_o(f_cnt), .tc_c_o(f_tc), .wrap_o(f_wrap)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic rst, input logic clr, input logic en, input logic up,
                                input logic load, input logic [3:0] val, input logic [3:0] cnt,
                                input logic wrap, input logic tc);
        vec_t v;
        v.rst = rst; v.clr = clr; v.en = en; v.up = up; v.load = load; v.val = val;
        v.exp_cnt = cnt; v.exp_wrap = wrap; v.exp_tc = tc;
        return v;
    endfunction

    vec_t vq[$];

    initial begin
        // rst clr en up ld val | cnt wrap tc
        vq.push_back(mk(1, 0, 1, 1, 0, 0,  0, 0, 0));
        for (int i = 1; i <= 9; i++)
            vq.push_back(mk(0, 0, 1, 1, 0, 0, 4'(i), 0, (i == 9)));
        vq.push_back(mk(0, 0, 1, 1, 0, 0,  0, 1, 0));
        vq.push_back(mk(0, 0, 1, 1, 0, 0,  1, 0, 0));
        // down through zero; load beats the simultaneous tick
        vq.push_back(mk(0, 0, 1, 0, 1, 2,  2, 0, 0));
        vq.push_back(mk(0, 0, 1, 0, 0, 0,  1, 0, 0));
        vq.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 1));
        vq.push_back(mk(0, 0, 1, 0, 0, 0,  9, 1, 0));
        vq.push_back(mk(0, 0, 1, 0, 0, 0,  8, 0, 0));
        // tc follows up combinationally
        vq.push_back(mk(0, 0, 0, 1, 0, 0,  8, 0, 0));
        vq.push_back(mk(0, 0, 0, 1, 1, 9,  9, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0,  9, 0, 0));
        // clamp, clr over load, load over tick, rst over everything
        vq.push_back(mk(0, 0, 0, 1, 1, 13, 9, 0, 1));
        vq.push_back(mk(0, 1, 1, 1, 1, 5,  0, 0, 0));
        vq.push_back(mk(0, 0, 1, 1, 1, 4,  4, 0, 0));
        vq.push_back(mk(0, 0, 1, 1, 0, 0,  5, 0, 0));
        vq.push_back(mk(1, 0, 1, 1, 1, 7,  0, 0, 0));
        // terminal-value behaviour: wrap or saturate
        vq.push_back(mk(0, 0, 0, 1, 1, 9,  9, 0, 1));
        vq.push_back(mk(0, 0, 1, 1, 0, 0,  SAT ? 4'd9 : 4'd0, 1, SAT));
        vq.push_back(mk(0, 0, 1, 1, 0, 0,  SAT ? 4'd9 : 4'd1, SAT, SAT));
        vq.push_back(mk(0, 0, 1, 0, 0, 0,  SAT ? 4'd8 : 4'd0, 0, !SAT));
        vq.push_back(mk(0, 0, 0, 0, 1, 0,  0, 0, 1));
        vq.push_back(mk(0, 0, 1, 0, 0, 0,  SAT ? 4'd0 : 4'd9, 1, SAT));
        vq.push_back(mk(0, 0, 0, 0, 0, 0,  SAT ? 4'd0 : 4'd9, 0, SAT));

        // Table on DUT A
        for (int i = 0; i < vq.size(); i++) begin
            a_rst = vq[i].rst; a_clr = vq[i].clr; a_en = vq[i].en; a_up = vq[i].up;
            a_load = vq[i].load; a_val = vq[i].val;
            step();
            chk($sformatf("a_count[%0d]", i), 32'(a_cnt),  32'(vq[i].exp_cnt));
            chk($sformatf("a_wrap[%0d]", i),  32'(a_wrap), 32'(vq[i].exp_wrap));
            chk($sformatf("a_tc[%0d]", i),    32'(a_tc),   32'(vq[i].exp_tc));
        end

        // Prescaler=3: steps after the 3rd and 6th enabled cycles
        begin
            logic pen[7];
            int   pexp[7];
            pen  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
            pexp = '{0, 0, 0, 1, 1, 1, 2};
            p_rst = 1'b1;
            step();
            chk("p_reset_count", 32'(p_cnt), 32'd0);
            chk("p_reset_tc", 32'(p_tc), 32'd0);
            p_rst = 1'b0;
            for (int i = 0; i < 7; i++) begin
                p_en = pen[i];
                step();
                chk($sformatf("p_count[%0d]", i), 32'(p_cnt), 32'(pexp[i]));
                chk($sformatf("p_wrap[%0d]", i), 32'(p_wrap), 32'd0);
            end
            // two enabled cycles, then clr discards the partial prescale
            p_en = 1'b1;
            step();
            step();
            chk("p_before_clr", 32'(p_cnt), 32'd2);
            p_clr = 1'b1;
            step();
            chk("p_clr_count", 32'(p_cnt), 32'd0);
            p_clr = 1'b0;
            step();
            chk("p_after_clr_1", 32'(p_cnt), 32'd0);
            step();
            chk("p_after_clr_2", 32'(p_cnt), 32'd0);
            step();
            chk("p_after_clr_3", 32'(p_cnt), 32'd1);
            // load restarts the prescaler too
            p_en = 1'b1;
            step();
            step();
            p_load = 1'b1; p_val = 4'd6;
            step();
            chk("p_load_count", 32'(p_cnt), 32'd6);
            p_load = 1'b0;
            step();
            step();
            chk("p_after_load_2", 32'(p_cnt), 32'd6);
            step();
            chk("p_after_load_3", 32'(p_cnt), 32'd7);
            p_en = 1'b0;
        end

        // Full range 8-bit, MODULO=256
        f_rst = 1'b1;
        step();
        chk("f_reset_count", 32'(f_cnt), 32'd0);
        f_rst = 1'b0;
        f_load = 1'b1; f_val = 8'd255;
        step();
        chk("f_load_count", 32'(f_cnt), 32'd255);
        chk("f_load_tc", 32'(f_tc), 32'd1);
        f_load = 1'b0; f_en = 1'b1; f_up = 1'b1;
        step();
        chk("f_wrap_count", 32'(f_cnt), SAT ? 32'd255 : 32'd0);
        chk("f_wrap_pulse", 32'(f_wrap), 32'd1);
        f_up = 1'b0;
        step();
        chk("f_down_count", 32'(f_cnt), SAT ? 32'd254 : 32'd255);
        chk("f_down_wrap", 32'(f_wrap), SAT ? 32'd0 : 32'd1);
        f_en = 1'b0;
        step();
        chk("f_idle_wrap", 32'(f_wrap), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
